// File: rtl/shiftreg_seq.sv
// shiftreg_seq: multi-bit shift register for the Booth multiplier datapath.
//
// Shifts the register by count positions in one of four modes. It moves at
// most STEP positions per clock and keeps the last bit shifted out, so that a
// radix-2 or radix-4 Booth controller can read its recoding bits directly.
// All state updates happen on the falling edge of clk, to match the rest of
// the Booth datapath.
//
// Ports:
//   clk        clock (state updates on the falling edge)
//   rst_n      asynchronous active-low reset
//   clear      synchronous clear (highest priority)
//   load       synchronous parallel load of data_in
//   data_in    [N-1:0]  parallel load value
//   serial_in  bit that fills the vacated MSBs in SRI mode
//   mode       [1:0]    00 ASR, 01 SRI, 10 LSL, 11 ROR
//   start      request a shift of count positions
//   count      [CW-1:0] total shift amount (values above N are clamped to N)
//   data_out   [N-1:0]  register contents
//   shift_out  last bit shifted out
//   busy       an operation is in progress
//   done       one-cycle completion pulse
//
// Handshake: start is sampled only while busy is low. On the edge that
// accepts start, busy rises. It stays high until the cycle after done. done
// is high for exactly the last busy cycle. start has no effect while busy is
// high, and that includes the DONE cycle. A clear or load aborts an operation
// in flight, and no done pulse is produced for it.
module shiftreg_seq #(
  parameter int N    = 8,
  parameter int STEP = 2,
  parameter int CW   = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          load,
  input  logic [N-1:0]  data_in,
  input  logic          serial_in,
  input  logic [1:0]    mode,
  input  logic          start,
  input  logic [CW-1:0] count,
  output logic [N-1:0]  data_out,
  output logic          shift_out,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] M_ASR = 2'b00;
  localparam logic [1:0] M_SRI = 2'b01;
  localparam logic [1:0] M_LSL = 2'b10;
  localparam logic [1:0] M_ROR = 2'b11;

  localparam logic [CW-1:0] N_CW    = CW'(N);
  localparam logic [CW-1:0] STEP_CW = CW'(STEP);

  state_t          state, state_nx;
  logic [1:0]      mode_r;
  logic [CW-1:0]   remaining;
  logic [CW-1:0]   count_clamped;
  logic [CW-1:0]   amt;
  logic [N-1:0]    shift_val;
  logic            shift_bit;
  logic [2*N-1:0]  rot_wide;
  logic [N-1:0]    low_probe;
  logic [N-1:0]    high_probe;

  assign count_clamped = (count > N_CW) ? N_CW : count;
  assign amt           = (remaining > STEP_CW) ? STEP_CW : remaining;

  // Shifted value and exit bit for a shift of amt positions.
  // The exit bit is read with a shift rather than a variable bit-select. That
  // keeps the index width legal, and amt == 0 (outside SHIFT) stays harmless.
  always_comb begin
    shift_val  = data_out;
    shift_bit  = shift_out;
    rot_wide   = {data_out, data_out} >> amt;
    low_probe  = data_out >> (amt - CW'(1));   // bit 0 = D[amt-1]
    high_probe = data_out >> (N_CW - amt);     // bit 0 = D[N-amt]
    case (mode_r)
      M_ASR: begin
        shift_val = $unsigned($signed(data_out) >>> amt);
        shift_bit = low_probe[0];
      end
      M_SRI: begin
        shift_val = (data_out >> amt) | (serial_in ? ~({N{1'b1}} >> amt) : '0);
        shift_bit = low_probe[0];
      end
      M_LSL: begin
        shift_val = data_out << amt;
        shift_bit = high_probe[0];
      end
      M_ROR: begin
        shift_val = rot_wide[N-1:0];
        shift_bit = low_probe[0];
      end
      default: begin
        shift_val = data_out;
        shift_bit = shift_out;
      end
    endcase
  end

  // State register.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic. clear and load override the sequencer.
  always_comb begin
    state_nx = state;
    if (clear || load) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state_nx = (count_clamped != '0) ? S_SHIFT : S_DONE;
        S_SHIFT: if (remaining == amt) state_nx = S_DONE;
        S_DONE:  state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Output logic.
  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // Datapath: register contents, exit bit, and the latched operation.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      shift_out <= 1'b0;
      mode_r    <= M_ASR;
      remaining <= '0;
    end else if (clear) begin
      data_out  <= '0;
      shift_out <= 1'b0;
      remaining <= '0;
    end else if (load) begin
      data_out  <= data_in;
      shift_out <= 1'b0;
      remaining <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_r    <= mode;
            remaining <= count_clamped;
          end
        end
        S_SHIFT: begin
          data_out  <= shift_val;
          shift_out <= shift_bit;
          remaining <= remaining - amt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shiftreg_seq.sv
// tb_shiftreg_seq: testbench for shiftreg_seq (N=8, STEP=2).
// The reference model shifts one bit at a time: an a-position shift is
// a repeated single-bit move. It predicts register contents, exit bit and
// busy/done cycle by cycle, working from the operation count alone.
module tb_shiftreg_seq;

  localparam int N    = 8;
  localparam int STEP = 2;
  localparam int CW   = $clog2(N + 1);

  // Clock / reset
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          load = 1'b0;
  logic [N-1:0]  data_in = '0;
  logic          serial_in = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          start = 1'b0;
  logic [CW-1:0] count = '0;
  logic [N-1:0]  data_out;
  logic          shift_out;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  shiftreg_seq #(.N(N), .STEP(STEP), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .data_in(data_in),
    .serial_in(serial_in), .mode(mode), .start(start), .count(count),
    .data_out(data_out), .shift_out(shift_out), .busy(busy), .done(done)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [N-1:0] m_data = '0;
  logic         m_so   = 1'b0;

  // The active edge is the falling edge. Sample and drive 1 ns after it.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [N+2:0] obs, input logic [N+2:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed={data,so,busy,done}=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [N-1:0] d, input logic so,
                         input logic b, input logic dn);
    chk(tag, {data_out, shift_out, busy, done}, {d, so, b, dn});
  endtask

  task automatic chk_data(input string tag, input logic [N-1:0] d);
    total++;
    assert (data_out === d)
    else begin
      bad++;
      $error("FAIL %s observed data=%h expected=%h", tag, data_out, d);
    end
  endtask

  // Model: move the register by one position in the given mode.
  task automatic step1(input logic [1:0] md, input logic si);
    case (md)
      2'b00: begin m_so = m_data[0];   m_data = {m_data[N-1], m_data[N-1:1]}; end
      2'b01: begin m_so = m_data[0];   m_data = {si, m_data[N-1:1]};          end
      2'b10: begin m_so = m_data[N-1]; m_data = {m_data[N-2:0], 1'b0};        end
      default: begin m_so = m_data[0]; m_data = {m_data[0], m_data[N-1:1]};   end
    endcase
  endtask

  // Driver tasks
  task automatic do_load(input logic [N-1:0] v, input string tag);
    data_in = v; load = 1'b1;
    tick();
    load = 1'b0;
    m_data = v; m_so = 1'b0;
    chk_all(tag, m_data, m_so, 1'b0, 1'b0);
  endtask

  task automatic do_clear(input string tag);
    clear = 1'b1; load = 1'b1; data_in = 8'hFF;   // clear wins over load
    tick();
    clear = 1'b0; load = 1'b0;
    m_data = '0; m_so = 1'b0;
    chk_all(tag, m_data, m_so, 1'b0, 1'b0);
  endtask

  // Run one full operation and check every cycle. hold_start keeps start
  // high and scrambles mode/count during the operation; neither may matter.
  task automatic run_op(input logic [1:0] md, input int cnt, input logic si,
                        input bit hold_start, input string tag);
    int c, rem, k, a;
    mode = md; count = CW'(cnt); serial_in = si; start = 1'b1;
    tick();
    if (!hold_start) start = 1'b0;
    else begin
      mode  = ~md;
      count = CW'($urandom_range(0, N));
    end
    c   = (cnt > N) ? N : cnt;
    rem = c;
    k   = (c + STEP - 1) / STEP;
    chk_all({tag, ":start"}, m_data, m_so, 1'b1, (c == 0));
    for (int i = 1; i <= k; i++) begin
      a = (rem < STEP) ? rem : STEP;
      repeat (a) step1(md, si);
      rem -= a;
      tick();
      chk_all($sformatf("%s:shift%0d", tag, i), m_data, m_so, 1'b1, (rem == 0));
    end
    tick();
    chk_all({tag, ":idle"}, m_data, m_so, 1'b0, 1'b0);
    start = 1'b0;
  endtask

  initial begin
    // Reset
    rst_n = 1'b0;
    #2;
    chk_all("reset", '0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_all("post_reset", '0, 1'b0, 1'b0, 1'b0);

    // 1: ASR 3 on B4
    do_load(8'hB4, "t1_load");
    run_op(2'b00, 3, 1'b0, 1'b0, "t1_asr");
    chk_data("t1_final", 8'hF6);

    // 2: LSL 5 on 8B
    do_load(8'h8B, "t2_load");
    run_op(2'b10, 5, 1'b0, 1'b0, "t2_lsl");
    chk_data("t2_final", 8'h60);

    // 3: SRI 2 with serial_in=1 on 00
    do_load(8'h00, "t3_load");
    run_op(2'b01, 2, 1'b1, 1'b0, "t3_sri");
    chk_data("t3_final", 8'hC0);

    // 4: ROR 12 clamps to 8, value returns
    do_load(8'h5A, "t4_load");
    run_op(2'b11, 12, 1'b0, 1'b0, "t4_ror");
    chk_data("t4_final", 8'h5A);

    // 5: count 0
    run_op(2'b00, 0, 1'b0, 1'b0, "t5_zero");

    // 6: start held high through the operation, mode/count scrambled
    do_load(8'hC3, "t6_load");
    run_op(2'b00, 5, 1'b0, 1'b1, "t6_hold");

    // 7: load mid-SHIFT aborts without a done pulse
    do_load(8'h96, "t7_load");
    mode = 2'b00; count = CW'(8); start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("t7_start", m_data, m_so, 1'b1, 1'b0);
    step1(2'b00, 1'b0); step1(2'b00, 1'b0);
    tick();
    chk_all("t7_shift1", m_data, m_so, 1'b1, 1'b0);
    do_load(8'h11, "t7_abort");
    tick();
    chk_all("t7_no_done", 8'h11, 1'b0, 1'b0, 1'b0);

    // 8: asynchronous reset mid-SHIFT
    do_load(8'hE7, "t8_load");
    mode = 2'b11; count = CW'(6); start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk_all("t8_async_reset", '0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    m_data = '0; m_so = 1'b0;
    tick();
    chk_all("t8_after_reset", m_data, m_so, 1'b0, 1'b0);

    // clear beats load
    do_load(8'h3C, "clr_load");
    do_clear("clr_prio");

    // Randomized operations against the model
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0)
        do_load(N'($urandom), $sformatf("rnd%0d_load", n));
      run_op(2'($urandom_range(0, 3)), $urandom_range(0, N + 4),
             1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
             $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
